// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: command sequencer for the systolic alignment array.
// Accepts one command (B segment, A address and A length). It streams A from
// the base memory one base per cycle with a one-cycle prefetch, drains the
// wavefront through the last PE, and then reports completion or abort.
module pe_array_ctrl #(
  parameter int NUM_PE = 64,
  parameter int LEN_W  = 16,
  parameter int AW     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [2*NUM_PE-1:0]   i_cmd_B,
  input  logic [AW-1:0]         i_cmd_A_addr,
  input  logic [LEN_W-1:0]      i_cmd_A_len,
  input  logic                  i_abort,
  output logic                  o_mem_rd,
  output logic [AW-1:0]         o_mem_addr,
  input  logic [1:0]            i_mem_data,
  output logic                  o_pe_start,
  output logic                  o_pe_stop,
  output logic [2*NUM_PE-1:0]   o_pe_B,
  output logic [1:0]            o_pe_A,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_aborted
);

  localparam int CW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PREF, S_RUN, S_DRAIN, S_ABORT, S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [2*NUM_PE-1:0]  b_q, b_d;
  logic [AW-1:0]        addr_q, addr_d;     // address of the next A base to read
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     k_q, k_d;           // index of the A base presented this cycle
  logic [CW-1:0]        cnt_q, cnt_d;       // drain cycles remaining
  logic                 aborted_q, aborted_d;

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the same pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      b_q       <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state, memory read requests and array controls.
  // NOTE: every signal written here gets a default first; otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    addr_d      = addr_q;
    len_d       = len_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    aborted_d   = aborted_q;
    o_cmd_ready = 1'b0;
    o_mem_rd    = 1'b0;
    o_mem_addr  = '0;
    o_pe_start  = 1'b0;
    o_pe_stop   = 1'b0;
    o_pe_A      = 2'b00;
    o_done      = 1'b0;
    o_aborted   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          b_d       = i_cmd_B;
          len_d     = i_cmd_A_len;
          aborted_d = 1'b0;
          if (i_cmd_A_len == '0) begin
            state_d = S_FIN;
          end else begin
            // Prefetch base 0 so it is on i_mem_data during the start cycle.
            o_mem_rd   = 1'b1;
            o_mem_addr = i_cmd_A_addr;
            addr_d     = i_cmd_A_addr + AW'(1);
            state_d    = S_PREF;
          end
        end
      end

      S_PREF: begin
        o_pe_start = 1'b1;
        o_pe_A     = i_mem_data;
        k_d        = LEN_W'(1);
        if (len_q > LEN_W'(1)) begin
          o_mem_rd   = 1'b1;
          o_mem_addr = addr_q;
          addr_d     = addr_q + AW'(1);
        end
        if (i_abort) begin
          state_d = S_ABORT;
        end else if (len_q == LEN_W'(1)) begin
          cnt_d   = CW'(NUM_PE - 1);
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        o_pe_A = i_mem_data;
        k_d    = k_q + LEN_W'(1);
        if (k_q < len_q - LEN_W'(1)) begin
          o_mem_rd   = 1'b1;
          o_mem_addr = addr_q;
          addr_d     = addr_q + AW'(1);
        end
        if (i_abort) begin
          state_d = S_ABORT;
        end else if (k_q == len_q - LEN_W'(1)) begin
          cnt_d   = CW'(NUM_PE - 1);
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // A natural stop takes priority over an abort sampled in the same cycle.
        if (cnt_q == '0) begin
          o_pe_stop = 1'b1;
          state_d   = S_FIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (i_abort) state_d = S_ABORT;
        end
      end

      S_ABORT: begin
        o_pe_stop = 1'b1;
        aborted_d = 1'b1;
        state_d   = S_FIN;
      end

      S_FIN: begin
        o_done    = 1'b1;
        o_aborted = aborted_q;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign o_pe_B = b_q;
  assign o_busy = (state_q != S_IDLE);

endmodule
